regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the ID-stage register file. It shares the single regfile write port between the in-order pipeline writeback from MEM and a long-latency unit, such as mul/div or syscall results, that completes out of order. Long-latency results are buffered in a small FIFO and drained into idle writeback slots. The block tracks destination registers with pending long-latency writes so ID can stall on them, and requests a pipeline stall if the buffered writes are starved.

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
package regfile_arb_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One buffered long-latency result.
  typedef struct packed {
    logic [REG_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } lu_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until a free writeback slot.
module wb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      clr_n,
  input  logic      push,
  input  logic      pop,
  input  lu_entry_t wdata,
  output lu_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  lu_entry_t       mem [DEPTH];
  logic [PW-1:0]   wptr_q;
  logic [PW-1:0]   rptr_q;

  // Extra wrap bit separates full from empty when the indexes match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem[rptr_q[AW-1:0]];

  // Pointer update; reset discards all buffered entries.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and buffered
// long-latency results, tracks pending destinations, and flags starvation.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              wb_reg_write_en,
  input  logic [REG_W-1:0]  wb_reg_write_num,
  input  logic [DATA_W-1:0] wb_reg_write_data,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_num,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              lu_issue,
  input  logic [REG_W-1:0]  lu_issue_num,
  input  logic [REG_W-1:0]  query1_num,
  input  logic [REG_W-1:0]  query2_num,
  output logic              query_hazard,
  output logic              stall_req,
  output logic              rf_write_en,
  output logic [REG_W-1:0]  rf_write_num,
  output logic [DATA_W-1:0] rf_write_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  lu_entry_t   head;
  lu_entry_t   push_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        slot_busy;
  logic        push;
  logic        pop;
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        stall_q;

  assign push_entry = '{num: lu_num, data: lu_data};
  assign slot_busy  = wb_reg_write_en && (wb_reg_write_num != REG_ZERO);
  assign lu_ready   = clr_n && !fifo_full;
  assign push       = lu_valid && lu_ready;
  assign pop        = !slot_busy && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write-port mux: pipeline first, otherwise drain the FIFO head.
  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_num  = REG_ZERO;
    rf_write_data = '0;
    if (slot_busy) begin
      rf_write_en   = clr_n;
      rf_write_num  = wb_reg_write_num;
      rf_write_data = wb_reg_write_data;
    end else if (pop) begin
      rf_write_en   = (head.num != REG_ZERO);
      rf_write_num  = head.num;
      rf_write_data = head.data;
    end
  end

  // Scoreboard next state; a same-edge issue overrides the drain clear.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head.num != REG_ZERO)) busy_d[head.num] = 1'b0;
    if (lu_issue && (lu_issue_num != REG_ZERO)) busy_d[lu_issue_num] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign query_hazard = ((query1_num != REG_ZERO) && busy_q[query1_num]) ||
                        ((query2_num != REG_ZERO) && busy_q[query2_num]);

  // Starvation counter next state, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || pop) begin
      cnt_d = 4'd0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Scoreboard, counter and stall request registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy_q  <= '0;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= (cnt_q == LIMIT) && !pop && !fifo_empty;
    end
  end

  assign stall_req = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, per-cycle vector table, mid-run reset.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        clr_n;
  logic        wb_reg_write_en;
  logic [4:0]  wb_reg_write_num;
  logic [31:0] wb_reg_write_data;
  logic        lu_valid;
  logic [4:0]  lu_num;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        lu_issue;
  logic [4:0]  lu_issue_num;
  logic [4:0]  query1_num;
  logic [4:0]  query2_num;
  logic        query_hazard;
  logic        stall_req;
  logic        rf_write_en;
  logic [4:0]  rf_write_num;
  logic [31:0] rf_write_data;

  int checks;
  int errors;

  regfile_wb_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk               (clk),
    .clr_n             (clr_n),
    .wb_reg_write_en   (wb_reg_write_en),
    .wb_reg_write_num  (wb_reg_write_num),
    .wb_reg_write_data (wb_reg_write_data),
    .lu_valid          (lu_valid),
    .lu_num            (lu_num),
    .lu_data           (lu_data),
    .lu_ready          (lu_ready),
    .lu_issue          (lu_issue),
    .lu_issue_num      (lu_issue_num),
    .query1_num        (query1_num),
    .query2_num        (query2_num),
    .query_hazard      (query_hazard),
    .stall_req         (stall_req),
    .rf_write_en       (rf_write_en),
    .rf_write_num      (rf_write_num),
    .rf_write_data     (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        lv;
    logic [4:0]  ln;
    logic [31:0] ld;
    logic        iss;
    logic [4:0]  inum;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic [40:0] exp_out; // {ready, hazard, stall, en, num, data}
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] W3 = 32'h1111_0003;

  function automatic vec_t mk(input logic wb_en, input logic [4:0] wb_num, input logic [31:0] wb_data,
                              input logic lv, input logic [4:0] ln, input logic [31:0] ld,
                              input logic iss, input logic [4:0] inum,
                              input logic [4:0] q1, input logic [4:0] q2,
                              input logic er, input logic eh, input logic es,
                              input logic ee, input logic [4:0] en, input logic [31:0] ed);
    vec_t v;
    v.wb_en = wb_en; v.wb_num = wb_num; v.wb_data = wb_data;
    v.lv = lv; v.ln = ln; v.ld = ld;
    v.iss = iss; v.inum = inum; v.q1 = q1; v.q2 = q2;
    v.exp_out = {er, eh, es, ee, en, ed};
    return v;
  endfunction

  function automatic logic [40:0] actual_out();
    return {lu_ready, query_hazard, stall_req, rf_write_en, rf_write_num, rf_write_data};
  endfunction

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h ({ready,haz,stall,en,num,data})", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb_reg_write_en   = v.wb_en;
    wb_reg_write_num  = v.wb_num;
    wb_reg_write_data = v.wb_data;
    lu_valid          = v.lv;
    lu_num            = v.ln;
    lu_data           = v.ld;
    lu_issue          = v.iss;
    lu_issue_num      = v.inum;
    query1_num        = v.q1;
    query2_num        = v.q2;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //                 wb_en num  data          lv  ln  ld            iss inum q1 q2   rdy haz stl en num data
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 5,  5, 0,  1, 0, 0, 0, 0,  0));            // issue 5
    vecs.push_back(mk(0, 0,  0,            1, 5,  32'hDEADBEEF, 0, 0,  5, 0,  1, 1, 0, 0, 0,  0));            // push 5
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  5, 0,  1, 1, 0, 1, 5,  32'hDEADBEEF)); // drain 5
    vecs.push_back(mk(1, 0,  32'h1234,     0, 0,  0,            0, 0,  5, 0,  1, 0, 0, 0, 0,  0));            // $0 wb, empty
    vecs.push_back(mk(1, 3,  W3,           0, 0,  0,            1, 8,  8, 0,  1, 0, 0, 1, 3,  W3));
    vecs.push_back(mk(1, 3,  W3,           1, 8,  32'hA8,       1, 9,  8, 9,  1, 1, 0, 1, 3,  W3));           // push 8
    vecs.push_back(mk(1, 3,  W3,           1, 9,  32'hA9,       0, 0,  9, 0,  1, 1, 0, 1, 3,  W3));           // push 9, blocked 1
    vecs.push_back(mk(1, 3,  W3,           1, 10, 32'hAA,       0, 0,  0, 0,  0, 0, 0, 1, 3,  W3));           // full, held
    vecs.push_back(mk(1, 3,  W3,           1, 10, 32'hAA,       0, 0,  0, 0,  0, 0, 0, 1, 3,  W3));
    vecs.push_back(mk(1, 3,  W3,           1, 10, 32'hAA,       0, 0,  0, 0,  0, 0, 0, 1, 3,  W3));
    vecs.push_back(mk(1, 3,  W3,           1, 10, 32'hAA,       0, 0,  0, 0,  0, 0, 0, 1, 3,  W3));
    vecs.push_back(mk(1, 3,  W3,           1, 10, 32'hAA,       0, 0,  0, 0,  0, 0, 1, 1, 3,  W3));           // stall_req
    vecs.push_back(mk(0, 3,  W3,           1, 10, 32'hAA,       0, 0,  8, 0,  0, 1, 1, 1, 8,  32'hA8));       // pop, no reuse
    vecs.push_back(mk(1, 3,  W3,           1, 10, 32'hAA,       0, 0,  8, 0,  1, 0, 0, 1, 3,  W3));           // stall drops
    vecs.push_back(mk(1, 0,  32'h5555,     0, 0,  0,            0, 0,  9, 0,  0, 1, 0, 1, 9,  32'hA9));       // $0 wb drains
    vecs.push_back(mk(0, 0,  0,            1, 11, 32'hBB,       1, 0,  0, 10, 1, 0, 0, 1, 10, 32'hAA));       // push+pop, issue $0
    vecs.push_back(mk(0, 0,  0,            1, 0,  0,            0, 0,  0, 0,  1, 0, 0, 1, 11, 32'hBB));       // occupancy kept
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 0,  1, 0, 0, 0, 0,  0));            // $0 entry popped
    vecs.push_back(mk(0, 0,  0,            1, 12, 32'hCC,       0, 0,  0, 0,  1, 0, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 7,  0, 0,  1, 0, 0, 1, 12, 32'hCC));       // issue 7
    vecs.push_back(mk(0, 0,  0,            1, 7,  32'h77,       0, 0,  7, 0,  1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 7,  7, 0,  1, 1, 0, 1, 7,  32'h77));       // pop 7 + issue 7
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  7, 0,  1, 1, 0, 0, 0,  0));            // set wins
    vecs.push_back(mk(0, 0,  0,            1, 7,  32'h78,       0, 0,  4, 7,  1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 7,  1, 1, 0, 1, 7,  32'h78));
    vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,  0, 7,  1, 0, 0, 0, 0,  0));            // cleared

    // Reset held three cycles with traffic offered.
    clr_n = 1'b0;
    drive(mk(1, 3, W3, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("reset_c%0d", c),
            {lu_ready, rf_write_en, stall_req, 38'd0}, 41'd0);
    end
    clr_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("release_ready", {40'd0, lu_ready}, 41'd1);

    // One vector per clock cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), actual_out(), vecs[i].exp_out);
      @(posedge clk); #1;
    end

    // Reset in the middle of operation discards entries and busy bits.
    drive(mk(1, 3, W3, 1, 13, 32'h13, 1, 13, 13, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(1, 3, W3, 1, 14, 32'h14, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_reset_hazard", {40'd0, query_hazard}, 41'd1);
    clr_n = 1'b0;
    #1;
    check("midreset_outputs", {lu_ready, rf_write_en, stall_req, query_hazard, 37'd0}, 41'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("after_midreset", actual_out(), {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});
    @(posedge clk); #1;
    check("after_midreset_idle", actual_out(), {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
